reg_writeback: RTL
==================

# reg_writeback

Writeback stage that is the sole writer of the architectural register file. It accepts completed results from the ALU and from the load unit over valid/ready handshakes. It formats load data by size, sign and byte offset, arbitrates between the two sources with starvation protection, and drives the register file write port. It also presents the in-flight write as a bypass to decode.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- STARVE_LIMIT, 3, consecutive ALU stall cycles before the ALU is forced to win.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid.
- alu_rd  in  REG_ADDR_WIDTH  ALU destination register.
- alu_data  in  32 (arch_reg)  ALU result.
- mem_valid  in  1  load result valid.
- mem_ready  out  1  load result accepted this cycle when high with mem_valid.
- mem_rd  in  REG_ADDR_WIDTH  load destination register.
- mem_word  in  32  raw aligned memory word.
- mem_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- mem_offset  in  2  byte address bits [1:0].
- rf_addr_rd  out  REG_ADDR_WIDTH  register file write address.
- rf_data_rd  out  32 (arch_reg)  register file write data.
- rf_write_enable  out  1  register file write strobe.
- byp_valid, byp_addr, byp_data  out  1/REG_ADDR_WIDTH/32  copy of the pending write, for forwarding.
- load_fault  out  1  one-cycle pulse on a misaligned load or an illegal funct3.

## Operation
- Handshake: a transfer happens when valid and ready are both high at the posedge. The producer holds rd and data stable while valid is high and ready is low.
- Default arbitration: mem wins. mem_ready = 1 and alu_ready = !mem_valid.
- Starvation counter (2 bits):
  - Increments each cycle alu_valid is high and the ALU is not accepted.
  - Clears on ALU acceptance or when alu_valid is low.
  - At STARVE_LIMIT, the next cycle forces alu_ready = 1 and mem_ready = 0. The counter clears on that acceptance.
- Load formatting (sub-module):
  - LB/LBU select byte mem_offset.
  - LH/LHU select the halfword at mem_offset[1].
  - LW takes the whole word.
  - Signed types sign-extend; unsigned types zero-extend.
- Load faults:
  - Misaligned: LH/LHU with mem_offset[0]=1, or LW with mem_offset≠0.
  - Illegal funct3: 011, 110 or 111.
  - On a fault the transfer is still accepted, no write occurs, and load_fault pulses the following cycle.
- Writes to rd=0 are accepted and dropped: rf_write_enable stays low and byp_valid stays low.
- byp_* mirrors rf_* exactly: byp_valid = rf_write_enable.

## Timing
- Output register stage: a transfer accepted at edge N drives rf_write_enable, rf_addr_rd and rf_data_rd during cycle N+1. The register file commits at edge N+1.
- Throughput: one write per cycle, with no bubbles between back-to-back transfers.
- rf_write_enable, byp_valid and load_fault are high for exactly one cycle per accepted transfer, unless the next cycle also carries a transfer.
- Ready signals are combinational from valids and the starvation counter. There is no combinational path from data to ready.
- Reset (asynchronous, any time, including mid-transfer):
  - rf_write_enable=0, rf_addr_rd=0, rf_data_rd=0, byp_*=0, load_fault=0, starvation counter=0.
  - While reset_n is low, alu_ready=0 and mem_ready=0.
  - A transfer coincident with reset assertion is lost.
- Simultaneous valids: mem is accepted and the ALU counter increments. With STARVE_LIMIT=3, a continuously valid ALU is accepted on its 4th cycle of valid.

## Structure
- arch_reg and load funct3 constants (LB_F3…LHU_F3) belong in the shared instructions package.
- Sub-module load_formatter: combinational; inputs mem_word, mem_funct3, mem_offset; outputs data and fault.
- Top level contains the arbiter, the starvation counter and the output register.

## Test plan
- Single ALU write: alu_valid, rd=5, data=0x1234_5678 → next cycle rf_write_enable=1, addr=5, data=0x1234_5678, byp_valid=1.
- Load formatting: mem_word=0x80FF_7F01.
  - LB offset 3 → 0xFFFF_FF80.
  - LBU offset 3 → 0x0000_0080.
  - LH offset 2 → 0xFFFF_80FF.
  - LHU offset 0 → 0x0000_7F01.
- Contention: both valid continuously, STARVE_LIMIT=3 → accept order mem, mem, mem, alu, mem…; alu_ready is high exactly every 4th cycle.
- rd=0: alu_valid, rd=0, data=0xDEAD_BEEF → accepted (alu_ready=1); rf_write_enable stays 0.
- Fault: LW offset 2, rd=7 → accepted; no write; load_fault high for one cycle at N+1.
- Reset mid-stream: assert reset_n=0 between edges during back-to-back writes → all outputs 0 immediately; readys 0; first write after release carries the post-reset transfer only.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// Shared instruction definitions for the writeback stage: architectural register
// type and load funct3 encodings.
package reg_writeback_pkg;

  typedef logic [31:0] arch_reg;

  localparam logic [2:0] LB_F3  = 3'b000;
  localparam logic [2:0] LH_F3  = 3'b001;
  localparam logic [2:0] LW_F3  = 3'b010;
  localparam logic [2:0] LBU_F3 = 3'b100;
  localparam logic [2:0] LHU_F3 = 3'b101;

  function automatic arch_reg extend8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic arch_reg extend16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/reg_writeback_load_formatter.sv
// Combinational load formatter: selects and extends the loaded byte/halfword/word
// and flags misaligned accesses and illegal load types.
module load_formatter
  import reg_writeback_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [2:0]  mem_funct3,
  input  logic [1:0]  mem_offset,
  output arch_reg     data,
  output logic        fault
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = mem_word[{mem_offset, 3'b000} +: 8];
  assign w_half = mem_offset[1] ? mem_word[31:16] : mem_word[15:0];

  // Format by load type; unknown encodings produce zero data and a fault.
  always_comb begin
    data  = 32'd0;
    fault = 1'b0;
    case (mem_funct3)
      LB_F3:  data = extend8(w_byte, 1'b1);
      LBU_F3: data = extend8(w_byte, 1'b0);
      LH_F3: begin
        data  = extend16(w_half, 1'b1);
        fault = mem_offset[0];
      end
      LHU_F3: begin
        data  = extend16(w_half, 1'b0);
        fault = mem_offset[0];
      end
      LW_F3: begin
        data  = mem_word;
        fault = (mem_offset != 2'd0);
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: arbitrates ALU and load results (mem priority with ALU
// starvation protection) into a registered register-file write / bypass port.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int STARVE_LIMIT   = 3
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  arch_reg                   alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [31:0]               mem_word,
  input  logic [2:0]                mem_funct3,
  input  logic [1:0]                mem_offset,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_rd,
  output arch_reg                   rf_data_rd,
  output logic                      rf_write_enable,
  output logic                      byp_valid,
  output logic [REG_ADDR_WIDTH-1:0] byp_addr,
  output arch_reg                   byp_data,
  output logic                      load_fault
);

  localparam logic [1:0] LIMIT_C = 2'(STARVE_LIMIT);

  logic [1:0]                r_starve;
  logic                      r_we;
  logic [REG_ADDR_WIDTH-1:0] r_addr;
  arch_reg                   r_data;
  logic                      r_fault;

  logic    w_force;
  logic    w_alu_acc;
  logic    w_mem_acc;
  arch_reg w_ld_data;
  logic    w_ld_fault;

  // Forcing only applies while the ALU is still asking, so mem never loses a slot for nothing.
  assign w_force   = alu_valid && (r_starve >= LIMIT_C);
  assign mem_ready = reset_n && !w_force;
  assign alu_ready = reset_n && (w_force || !mem_valid);
  assign w_alu_acc = alu_valid && alu_ready;
  assign w_mem_acc = mem_valid && mem_ready;

  load_formatter u_load_formatter (
    .mem_word   (mem_word),
    .mem_funct3 (mem_funct3),
    .mem_offset (mem_offset),
    .data       (w_ld_data),
    .fault      (w_ld_fault)
  );

  // Starvation counter and the registered write/bypass/fault outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= 2'd0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= 32'd0;
      r_fault  <= 1'b0;
    end else begin
      if (w_alu_acc || !alu_valid) begin
        r_starve <= 2'd0;
      end else if (r_starve != 2'b11) begin
        r_starve <= r_starve + 2'd1;
      end else begin
        r_starve <= r_starve;
      end

      r_we    <= 1'b0;
      r_fault <= 1'b0;
      if (w_mem_acc) begin
        r_fault <= w_ld_fault;
        if (!w_ld_fault && (mem_rd != '0)) begin
          r_we   <= 1'b1;
          r_addr <= mem_rd;
          r_data <= w_ld_data;
        end
      end else if (w_alu_acc) begin
        if (alu_rd != '0) begin
          r_we   <= 1'b1;
          r_addr <= alu_rd;
          r_data <= alu_data;
        end
      end
    end
  end

  assign rf_write_enable = r_we;
  assign rf_addr_rd      = r_addr;
  assign rf_data_rd      = r_data;
  assign byp_valid       = r_we;
  assign byp_addr        = r_addr;
  assign byp_data        = r_data;
  assign load_fault      = r_fault;

endmodule
